// File: rtl/prbs_checker_if.sv
// ============================================================================
// Module  : prbs_checker_if
// Brief   : Word stream and status bundle between a pseudo-random word sink
//           and its checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface prbs_checker_if #(
    parameter int CWIDTH = 16
) ();
    logic              in_valid;
    logic [31:0]       din;
    logic              cnt_clr;
    logic              locked;
    logic              err;
    logic [CWIDTH-1:0] err_count;
    logic [CWIDTH-1:0] word_count;

    modport master (
        output in_valid, din, cnt_clr,
        input  locked, err, err_count, word_count
    );

    modport slave (
        input  in_valid, din, cnt_clr,
        output locked, err, err_count, word_count
    );
endinterface

`default_nettype wire

// File: rtl/prbs_checker.sv
// ============================================================================
// Module  : prbs_checker
// Brief   : Locks onto a 32-bit pseudo-random word stream, flywheels the
//           prediction once locked and counts mismatched words. Define
//           PRBS_BIT_ERR_EN to count mismatched bits instead of words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_checker #(
    parameter int CWIDTH   = 16,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    prbs_checker_if.slave   bus
);

    localparam int c_match_w = $clog2(LOCK_CNT + 1);
    localparam int c_miss_w  = $clog2(LOSS_CNT + 1);
    localparam int c_sum_w   = ((CWIDTH > 6) ? CWIDTH : 6) + 1;

    localparam logic [0:0]           c_hunt       = 1'b0;
    localparam logic [0:0]           c_locked     = 1'b1;
    localparam logic [c_match_w-1:0] c_lock_last  = c_match_w'(LOCK_CNT - 1);
    localparam logic [c_miss_w-1:0]  c_loss_last  = c_miss_w'(LOSS_CNT - 1);
    localparam logic [CWIDTH-1:0]    c_cmax       = '1;

    logic [0:0]           r_state;
    logic [31:0]          r_exp;
    logic [c_match_w-1:0] r_match;
    logic [c_miss_w-1:0]  r_miss;
    logic                 r_err;
    logic [CWIDTH-1:0]    r_err_count;
    logic [CWIDTH-1:0]    r_word_count;

    logic                 w_match;
    logic [5:0]           w_inc;
    logic [c_sum_w-1:0]   w_err_sum;
    logic [CWIDTH-1:0]    w_err_next;
    logic [CWIDTH-1:0]    w_word_next;

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    assign w_match = (bus.din == r_exp);

`ifdef PRBS_BIT_ERR_EN
    logic [31:0] w_diff;
    assign w_diff = bus.din ^ r_exp;

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < 32; i++) begin
            w_inc = w_inc + {5'd0, w_diff[i]};
        end
    end
`else
    assign w_inc = 6'd1;
`endif

    // Wide sum so a 32-bit popcount cannot wrap a narrow counter before the clamp.
    assign w_err_sum   = c_sum_w'(r_err_count) + c_sum_w'(w_inc);
    assign w_err_next  = (w_err_sum > c_sum_w'(c_cmax)) ? c_cmax : w_err_sum[CWIDTH-1:0];
    assign w_word_next = (r_word_count == c_cmax) ? r_word_count : r_word_count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_hunt;
            r_exp        <= '0;
            r_match      <= '0;
            r_miss       <= '0;
            r_err        <= 1'b0;
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            r_err <= 1'b0;

            if (bus.in_valid) begin
                if (r_state == c_hunt) begin
                    // Re-seed from the received word; an all-zero word seeds 0, which never matches.
                    r_exp <= nxt(bus.din);
                    if (w_match && (bus.din != '0)) begin
                        r_match <= r_match + 1'b1;
                        if (r_match == c_lock_last) begin
                            r_state <= c_locked;
                            r_miss  <= '0;
                        end
                    end else begin
                        r_match <= '0;
                    end
                end else begin
                    // Flywheel: a corrupted word must not disturb the prediction.
                    r_exp <= nxt(r_exp);
                    if (w_match) begin
                        r_miss <= '0;
                    end else begin
                        r_err  <= 1'b1;
                        r_miss <= r_miss + 1'b1;
                        if (r_miss == c_loss_last) begin
                            r_state <= c_hunt;
                            r_match <= '0;
                        end
                    end
                end
            end

            if (bus.cnt_clr) begin
                r_err_count  <= '0;
                r_word_count <= '0;
            end else if (bus.in_valid && (r_state == c_locked)) begin
                r_word_count <= w_word_next;
                if (!w_match) begin
                    r_err_count <= w_err_next;
                end
            end
        end
    end

    assign bus.locked     = (r_state == c_locked);
    assign bus.err        = r_err;
    assign bus.err_count  = r_err_count;
    assign bus.word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// ============================================================================
// Module  : tb_prbs_checker
// Brief   : Vector-table bench for prbs_checker (16-bit and 4-bit counters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prbs_checker;

    typedef struct {
        bit          rst;
        bit          valid;
        logic [31:0] din;
        bit          clr;
        bit          locked;
        bit          err;
        int          ec;
        int          wc;
    } vec_t;

    typedef struct {
        bit    dut_b;
        bit    locked;
        bit    err;
        int    ec;
        int    wc;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    prbs_checker_if #(.CWIDTH(16)) bus_a ();
    prbs_checker_if #(.CWIDTH(4))  bus_b ();

    prbs_checker #(.CWIDTH(16), .LOCK_CNT(8), .LOSS_CNT(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    prbs_checker #(.CWIDTH(4), .LOCK_CNT(8), .LOSS_CNT(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    vec_t        tbl_a[$];
    vec_t        tbl_b[$];
    exp_t        sb[$];
    logic [31:0] p [0:63];
    int          checks = 0;
    int          passes = 0;

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic int inc(input logic [31:0] d, input logic [31:0] e);
`ifdef PRBS_BIT_ERR_EN
        return $countones(d ^ e);
`else
        if (d == e) return 0;
        return 1;
`endif
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic add(input bit b, input bit r, input bit v, input logic [31:0] d,
                       input bit c, input bit l, input bit er, input int ec, input int wc);
        vec_t t;
        t.rst = r; t.valid = v; t.din = d; t.clr = c;
        t.locked = l; t.err = er; t.ec = ec; t.wc = wc;
        if (b) tbl_b.push_back(t);
        else   tbl_a.push_back(t);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    task automatic apply(input bit b, input vec_t v, input string nm);
        exp_t e;
        if (!b) begin
            rst_a = v.rst; bus_a.in_valid = v.valid; bus_a.din = v.din; bus_a.cnt_clr = v.clr;
        end else begin
            rst_b = v.rst; bus_b.in_valid = v.valid; bus_b.din = v.din; bus_b.cnt_clr = v.clr;
        end
        e.dut_b = b; e.locked = v.locked; e.err = v.err; e.ec = v.ec; e.wc = v.wc; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (!e.dut_b) begin
            chk({e.name, " locked"},     int'(bus_a.locked),     int'(e.locked));
            chk({e.name, " err"},        int'(bus_a.err),        int'(e.err));
            chk({e.name, " err_count"},  int'(bus_a.err_count),  e.ec);
            chk({e.name, " word_count"}, int'(bus_a.word_count), e.wc);
        end else begin
            chk({e.name, " locked"},     int'(bus_b.locked),     int'(e.locked));
            chk({e.name, " err"},        int'(bus_b.err),        int'(e.err));
            chk({e.name, " err_count"},  int'(bus_b.err_count),  e.ec);
            chk({e.name, " word_count"}, int'(bus_b.word_count), e.wc);
        end
    endtask

    initial begin
        int ec;
        bus_a.in_valid = 1'b0; bus_a.din = '0; bus_a.cnt_clr = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.din = '0; bus_b.cnt_clr = 1'b0;

        p[0] = 32'h974CA351;
        for (int i = 1; i < 64; i++) p[i] = nxt(p[i-1]);

        // DUT A: reset, lock, single error, clear, loss of lock, zero stream, relock, reset.
        add(0, 1, 1, p[3], 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 1, p[i], 0, (i == 8), 0, 0, 0);
        add(0, 0, 1, p[9] ^ 32'h1, 0, 1, 1, 1, 1);
        add(0, 0, 1, p[10],        0, 1, 0, 1, 2);
        add(0, 0, 1, p[11],        0, 1, 0, 1, 3);
        add(0, 0, 1, p[12] ^ 32'h1, 0, 1, 1, 2, 4);
        add(0, 0, 1, p[13],        0, 1, 0, 2, 5);
        add(0, 0, 1, p[14] ^ 32'h1, 0, 1, 1, 3, 6);
        add(0, 0, 1, p[15],        0, 1, 0, 3, 7);
        add(0, 0, 1, p[16] ^ 32'h1, 1, 1, 1, 0, 0);
        add(0, 0, 1, p[17],        0, 1, 0, 0, 1);
        add(0, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0, 1);
        add(0, 0, 1, p[18],        0, 1, 0, 0, 2);
        ec = 0;
        for (int j = 0; j < 4; j++) begin
            ec += inc(32'hFFFFFFFF, p[19+j]);
            add(0, 0, 1, 32'hFFFFFFFF, 0, (j < 3), 1, ec, 3 + j);
        end
        add(0, 0, 0, 32'h0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) add(0, 0, 1, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 1, p[i], 0, (i == 8), 0, 0, 0);
        add(0, 0, 1, p[9], 0, 1, 0, 0, 1);
        add(0, 1, 1, p[10] ^ 32'h00FF, 0, 0, 0, 0, 0);
        add(0, 0, 1, p[0], 0, 0, 0, 0, 0);

        // DUT B: 4-bit counters saturate under alternating errors, then reset mid-stream.
        add(1, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(1, 0, 1, p[i], 0, (i == 8), 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            add(1, 0, 1, p[9 + 2*(k-1)] ^ 32'h1, 0, 1, 1, sat15(k), sat15(2*k - 1));
            add(1, 0, 1, p[10 + 2*(k-1)],        0, 1, 0, sat15(k), sat15(2*k));
        end
        add(1, 1, 1, p[49] ^ 32'h1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          0, 0, 0, 0, 0);

        for (int i = 0; i < tbl_a.size(); i++) apply(0, tbl_a[i], $sformatf("A%0d", i));
        for (int i = 0; i < tbl_b.size(); i++) apply(1, tbl_b[i], $sformatf("B%0d", i));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
